// File: rtl/led_sweep_ctrl_if.sv
// Bundle of the sweep controller's control, waypoint-write and LED counter signals.
// The master side belongs to whoever drives the controller (and owns the counter);
// the slave side belongs to the controller itself.
interface led_sweep_ctrl_if #(
  parameter int W  = 5,
  parameter int DW = 8
);
  logic          start;
  logic          abort;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [2:0]    num_points;
  logic          loop_en;
  logic [DW-1:0] dwell;
  logic [W-1:0]  cnt_val;
  logic          cnt_check;
  logic [W-1:0]  end_num;
  logic          up_down;
  logic          busy;
  logic [1:0]    seg_idx;
  logic          done;

  modport master (
    output start, abort, wr_en, wr_addr, wr_data, num_points, loop_en, dwell,
           cnt_val, cnt_check,
    input  end_num, up_down, busy, seg_idx, done
  );

  modport slave (
    input  start, abort, wr_en, wr_addr, wr_data, num_points, loop_en, dwell,
           cnt_val, cnt_check,
    output end_num, up_down, busy, seg_idx, done
  );
endinterface

// File: rtl/led_sweep_ctrl.sv
// Waypoint sweep controller for an up/down LED counter.
// Walks a small table of target values: for each waypoint it programs the
// counter's end_num/up_down, waits for the counter to arrive, dwells, then
// moves on. Optionally loops; abort and reset drop straight back to IDLE.
module led_sweep_ctrl #(
  parameter int W    = 5,
  parameter int NPTS = 4,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  led_sweep_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DWELL,
    FINISH
  } state_t;

  // seg_idx is only 2 bits wide, so a sweep can never use more than 4 entries.
  localparam logic [2:0] NPTS_CAP = (NPTS > 4) ? 3'd4 : 3'(NPTS);

  state_t        state_q, state_d;
  logic [W-1:0]  wp_q [NPTS];
  logic [W-1:0]  endNum_q, endNum_d;
  logic          upDown_q, upDown_d;
  logic [1:0]    segIdx_q, segIdx_d;
  logic [2:0]    npts_q, npts_d;
  logic [DW-1:0] dwellCnt_q, dwellCnt_d;

  logic [W-1:0]  curWp;
  logic          lastSeg;

  assign curWp   = wp_q[segIdx_q];
  assign lastSeg = (({1'b0, segIdx_q} + 3'd1) >= npts_q);

  // Waypoint table: writable in any state, read only when LOAD samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTS; i++) begin
        wp_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < NPTS; i++) begin
        if (bus.wr_addr == 2'(i)) begin
          wp_q[i] <= bus.wr_data;
        end
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      endNum_q   <= '0;
      upDown_q   <= 1'b1;
      segIdx_q   <= '0;
      npts_q     <= '0;
      dwellCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      endNum_q   <= endNum_d;
      upDown_q   <= upDown_d;
      segIdx_q   <= segIdx_d;
      npts_q     <= npts_d;
      dwellCnt_q <= dwellCnt_d;
    end
  end

  // Next-state logic; abort is applied last so it overrides every transition.
  always_comb begin
    state_d    = state_q;
    endNum_d   = endNum_q;
    upDown_d   = upDown_q;
    segIdx_d   = segIdx_q;
    npts_d     = npts_q;
    dwellCnt_d = dwellCnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.num_points != 3'd0)) begin
          npts_d   = (bus.num_points > NPTS_CAP) ? NPTS_CAP : bus.num_points;
          segIdx_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        endNum_d = curWp;
        upDown_d = (curWp >= bus.cnt_val);
        state_d  = SETTLE;
      end
      SETTLE: begin
        // The counter's check still reflects the previous target here.
        state_d = RUN;
      end
      RUN: begin
        if (bus.cnt_check && (bus.cnt_val == endNum_q)) begin
          dwellCnt_d = bus.dwell;
          state_d    = DWELL;
        end
      end
      DWELL: begin
        if (dwellCnt_q != '0) begin
          dwellCnt_d = dwellCnt_q - DW'(1);
        end else if (!lastSeg) begin
          segIdx_d = segIdx_q + 2'd1;
          state_d  = LOAD;
        end else if (bus.loop_en) begin
          segIdx_d = '0;
          state_d  = LOAD;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      endNum_d   = endNum_q;
      upDown_d   = upDown_q;
      segIdx_d   = segIdx_q;
      npts_d     = npts_q;
      dwellCnt_d = dwellCnt_q;
    end
  end

  assign bus.end_num = endNum_q;
  assign bus.up_down = upDown_q;
  assign bus.seg_idx = segIdx_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FINISH);

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl with a simple LED counter model attached.
// Expected behaviour is a per-cycle trace built from the sweep timing rules:
// each waypoint costs LOAD + SETTLE + (distance+1) RUN + (dwell+1) DWELL cycles.
module tb_led_sweep_ctrl;

   logic clk;
   logic rst;

   led_sweep_ctrl_if #(.W(5), .DW(8)) bus ();

   led_sweep_ctrl #(.W(5), .NPTS(4), .DW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int totalChecks;
   int badChecks;

   int wpModel [4];
   int modelPos;
   int modelEnd;
   bit modelUp;

   logic [4:0] cntVal;
   logic       cntCheck;

   assign bus.cnt_val   = cntVal;
   assign bus.cnt_check = cntCheck;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // LED counter model: steps one toward end_num in the commanded direction,
   // and reports arrival one cycle late.
   always @(posedge clk) begin
      if (rst) begin
         cntVal   <= '0;
         cntCheck <= 1'b0;
      end else begin
         cntCheck <= (cntVal == bus.end_num);
         if (bus.up_down && (cntVal < bus.end_num)) begin
            cntVal <= cntVal + 5'd1;
         end else if (!bus.up_down && (cntVal > bus.end_num)) begin
            cntVal <= cntVal - 5'd1;
         end
      end
   end

   // Compares one observed value with its expectation and tallies the result.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Packs the expected output fields into one comparable word.
   function automatic int packExp(input bit busy, input bit done, input int seg,
                                  input bit up, input int endv);
      return (int'(busy) << 9) | (int'(done) << 8) | ((seg & 3) << 6) |
             (int'(up) << 5) | (endv & 31);
   endfunction

   // Packs the observed DUT outputs the same way.
   function automatic int obs();
      return int'({bus.busy, bus.done, bus.seg_idx, bus.up_down, bus.end_num});
   endfunction

   // Drives the sweep control inputs.
   task automatic applyStimulus(input bit s, input int np, input bit lp, input int dw);
      bus.start      = s;
      bus.num_points = 3'(np);
      bus.loop_en    = lp;
      bus.dwell      = 8'(dw);
   endtask

   // Writes one waypoint and mirrors it in the model.
   task automatic writeWp(input int addr, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(addr);
      bus.wr_data = 5'(data);
      @(negedge clk);
      bus.wr_en   = 1'b0;
      wpModel[addr] = data;
   endtask

   // Clears the reference model to its post-reset state.
   task automatic modelReset();
      for (int i = 0; i < 4; i++) wpModel[i] = 0;
      modelPos = 0;
      modelEnd = 0;
      modelUp  = 1'b1;
   endtask

   // Applies a synchronous reset and checks the reset values.
   task automatic doReset();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.wr_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
      rst = 1'b0;
      modelReset();
   endtask

   // Runs one sweep from a negedge and compares every cycle with the trace.
   // cutSeg >= 0 asserts abort (or rst) in cycle cutOff of that segment.
   task automatic runSweep(input int np, input int dw, input int nSegIn, input bit loopMode,
                           input bit randMid, input int cutSeg, input int cutOff,
                           input bit cutRst);
      int expQ[$];
      int nEff, nSeg, pos, curEnd, idx, t, d, segLen, dropAt, cutAt, held;
      bit curUp, u;
      nEff   = (np > 4) ? 4 : np;
      nSeg   = loopMode ? nSegIn : nEff;
      pos    = modelPos;
      curEnd = modelEnd;
      curUp  = modelUp;
      dropAt = -1;
      cutAt  = -1;
      idx    = 0;
      for (int s = 0; s < nSeg; s++) begin
         idx    = s % nEff;
         t      = wpModel[idx];
         d      = (t >= pos) ? (t - pos) : (pos - t);
         u      = (t >= pos);
         segLen = d + dw + 4;
         if (s == cutSeg) cutAt = expQ.size() + cutOff;
         expQ.push_back(packExp(1'b1, 1'b0, idx, curUp, curEnd));
         for (int k = 1; k < segLen; k++) expQ.push_back(packExp(1'b1, 1'b0, idx, u, t));
         if (loopMode && (s == nSeg - 1)) dropAt = expQ.size() - (dw + 1);
         pos    = t;
         curEnd = t;
         curUp  = u;
      end
      expQ.push_back(packExp(1'b1, 1'b1, idx, curUp, curEnd));
      expQ.push_back(packExp(1'b0, 1'b0, idx, curUp, curEnd));

      applyStimulus(1'b1, np, loopMode, dw);
      for (int c = 0; c < expQ.size(); c++) begin
         @(negedge clk);
         checkOutput($sformatf("trace%0d", c), obs(), expQ[c]);
         if (c == cutAt) begin
            bus.start = 1'b0;
            if (cutRst) rst = 1'b1;
            else bus.abort = 1'b1;
            held = expQ[c] & ~(3 << 8);
            @(negedge clk);
            rst       = 1'b0;
            bus.abort = 1'b0;
            if (cutRst) begin
               checkOutput("cutRst0", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
               @(negedge clk);
               checkOutput("cutRst1", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
            end else begin
               checkOutput("abort0", obs(), held);
               @(negedge clk);
               checkOutput("abort1", obs(), held);
            end
            return;
         end
         if (randMid && (c < expQ.size() - 1)) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.num_points = 3'($urandom_range(0, 7));
         end else begin
            bus.start = 1'b0;
         end
         if (c == dropAt) bus.loop_en = 1'b0;
      end
      bus.start = 1'b0;
      modelPos = pos;
      modelEnd = curEnd;
      modelUp  = curUp;
   endtask

   // Main sequence covering the verification requirements.
   initial begin
      totalChecks = 0;
      badChecks   = 0;
      modelReset();
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.num_points = '0;
      bus.loop_en    = 1'b0;
      bus.dwell      = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
      rst = 1'b0;
      @(negedge clk);

      writeWp(0, 5);
      writeWp(1, 2);
      writeWp(2, 9);
      writeWp(3, 9);
      runSweep(3, 2, 0, 1'b0, 1'b0, -1, 0, 1'b0);
      runSweep(3, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0);

      writeWp(0, 3);
      writeWp(1, 1);
      runSweep(2, 1, 4, 1'b1, 1'b1, -1, 0, 1'b0);

      doReset();
      writeWp(0, 5);
      writeWp(1, 2);
      writeWp(2, 9);
      writeWp(3, 9);
      runSweep(3, 2, 0, 1'b0, 1'b0, 2, 3, 1'b0);

      doReset();
      writeWp(0, 5);
      writeWp(1, 2);
      writeWp(2, 9);
      writeWp(3, 9);
      runSweep(3, 2, 0, 1'b0, 1'b0, 0, 8, 1'b1);

      doReset();
      applyStimulus(1'b1, 0, 1'b0, 0);
      @(negedge clk);
      checkOutput("np0_a", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
      @(negedge clk);
      checkOutput("np0_b", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
      bus.start = 1'b0;

      applyStimulus(1'b1, 3, 1'b0, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      checkOutput("rstStart0", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));
      @(negedge clk);
      checkOutput("rstStart1", obs(), packExp(1'b0, 1'b0, 0, 1'b1, 0));

      $display("[TB] test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/led_sweep_ctrl.md
LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 5, giving the counter value width.
REQ-002 The block SHALL have parameter NPTS, default 4, giving the number of waypoint table entries.
REQ-003 The block SHALL have parameter DW, default 8, giving the dwell counter width.
REQ-004 Port clk, input, 1: the single clock; all state SHALL change only on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request to begin a sweep.
REQ-007 Port abort, input, 1: request to stop the current sweep.
REQ-008 Ports wr_en (input, 1), wr_addr (input, 2) and wr_data (input, W): waypoint table write port.
REQ-009 Port num_points, input, 3: number of waypoints in a sweep.
REQ-010 Port loop_en, input, 1: restart at waypoint 0 after the last waypoint.
REQ-011 Port dwell, input, DW: hold cycles at each waypoint.
REQ-012 Port cnt_val, input, W: connects to the LED counter's counter_out.
REQ-013 Port cnt_check, input, 1: connects to the LED counter's check.
REQ-014 Port end_num, output, W: drives the LED counter's end_num.
REQ-015 Port up_down, output, 1: drives the LED counter's up_down (1 = up).
REQ-016 Port busy, output, 1: high in every state except IDLE.
REQ-017 Port seg_idx, output, 2: index of the active waypoint.
REQ-018 Port done, output, 1: single-cycle pulse at the end of a non-looping sweep.

Function
REQ-019 On wr_en=1, wp[wr_addr] SHALL take wr_data at the clock edge, in any state; a write to the active entry SHALL take effect at the next LOAD.
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, SETTLE, RUN, DWELL and FINISH.
REQ-021 IDLE: start=1 with num_points!=0 SHALL latch npts=min(num_points,NPTS), set seg_idx=0 and go to LOAD.
REQ-022 IDLE: start=1 with num_points=0 SHALL be ignored.
REQ-023 start asserted outside IDLE SHALL be ignored.
REQ-024 LOAD: end_num SHALL take wp[seg_idx], and up_down SHALL be set to (wp[seg_idx] >= cnt_val); the next state SHALL be SETTLE.
REQ-025 SETTLE: the FSM SHALL spend exactly 1 cycle here and cnt_check SHALL be ignored, because the counter's check lags the new target by one cycle; the next state SHALL be RUN.
REQ-026 RUN: when cnt_check=1 and cnt_val==end_num, the FSM SHALL load dwell_cnt=dwell and go to DWELL; otherwise it SHALL remain in RUN.
REQ-027 DWELL: while dwell_cnt!=0, dwell_cnt SHALL decrement by 1 per cycle.
REQ-028 DWELL with dwell_cnt==0: if seg_idx<npts-1, seg_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-029 DWELL with dwell_cnt==0 on the last segment: with loop_en=1, seg_idx SHALL be set to 0 and the FSM SHALL go to LOAD; with loop_en=0, the FSM SHALL go to FINISH.
REQ-030 With dwell=0, the FSM SHALL spend exactly 1 cycle in DWELL; with dwell=D, it SHALL spend D+1 cycles.
REQ-031 loop_en SHALL be sampled at the DWELL exit decision; num_points SHALL be sampled only at start.
REQ-032 FINISH: done SHALL be 1 for exactly that cycle, and the FSM SHALL go to IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse, holding end_num and up_down at their current values; abort SHALL take priority over all other transitions.
REQ-034 A waypoint equal to the current cnt_val SHALL pass through RUN in 1 cycle, since the counter reports check=1.
REQ-035 end_num and up_down SHALL change only in LOAD.

Reset
REQ-036 rst=1 at a clock edge SHALL set state=IDLE, end_num=0, up_down=1, seg_idx=0, busy=0, done=0, dwell_cnt=0, npts=0 and all wp entries to 0.
REQ-037 rst SHALL take priority over abort, start and wr_en.
REQ-038 rst asserted mid-sweep SHALL end the sweep with no done pulse.

Verification
REQ-039 Reset, then write wp={5,2,9,9}, num_points=3, dwell=2, loop_en=0, start, with the counter model attached -> end_num sequence 5, 2, 9; up_down sequence 1, 0, 1; done pulses once; busy falls the cycle after done.
REQ-040 Same setup with dwell=0 -> DWELL lasts 1 cycle per waypoint; total cycles from start to done match the cycle model exactly.
REQ-041 loop_en=1, num_points=2, wp={3,1} -> seg_idx cycles 0, 1, 0, 1 with no done pulse; drop loop_en during the last DWELL -> done follows.
REQ-042 Assert abort in RUN while the counter is at 4 heading to 9 -> busy=0 next cycle, no done pulse, end_num holds 9.
REQ-043 Assert start with num_points=0 -> stays IDLE; assert start while busy -> no restart and seg_idx unchanged.
REQ-044 Assert rst during DWELL, and separately assert rst and start together -> all outputs at reset values and state IDLE on the next cycle.
